// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg
// Shared definitions for the UART transmit scheduler:
//   - register offsets of the UART window (CTRL, STAT, TXD)
//   - FSM state encoding and round-robin grant encoding
//   - status word layout
//   - the built-in ID message ROM and a byte lookup helper
package uart_tx_sched_pkg;

    localparam logic [31:0] CTRL_OFF = 32'h0000_0000;
    localparam logic [31:0] STAT_OFF = 32'h0000_0004;
    localparam logic [31:0] TXD_OFF  = 32'h0000_0008;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SEND_CPU = 2'd1;
    localparam logic [1:0] ST_SEND_MSG = 2'd2;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_MSG = 1'b1;

    // Status register bits, MSB first: {ovf, q_empty, q_full, msg_busy, tx_active}
    typedef struct packed {
        logic ovf;
        logic q_empty;
        logic q_full;
        logic msg_busy;
        logic tx_active;
    } stat_t;

    // ID message "2023211013"; byte 0 sits in the most significant position
    localparam int ID_LEN = 10;
    localparam logic [8*ID_LEN-1:0] ID_ROM = 80'h32_30_32_33_32_31_31_30_31_33;

    // Returns byte i of the ID message, 0 for indices past its end
    function automatic logic [7:0] id_rom_byte(input logic [31:0] i);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < ID_LEN; k++) begin
            if (i == 32'(k)) begin
                b = ID_ROM[8*(ID_LEN-1-k) +: 8];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous FIFO holding CPU bytes waiting for the UART transmitter.
// A push into a full FIFO is ignored even if a pop happens in the same cycle;
// a pop from an empty FIFO is ignored.
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   push, wdata     write strobe and data
//   pop             remove the head entry
//   rdata           current head entry (valid when !empty)
//   full, empty     occupancy flags
module uart_tx_fifo
    import uart_tx_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Arbitrates the UART transmitter between CPU bytes written through a small
// register window and a built-in ID message. Grants alternate round robin when
// both are waiting; a CPU grant sends one byte, a message grant sends the
// whole message without interruption.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i    CPU bus access (CTRL +0, STAT +4, TXD +8)
//   cpu_rdata_o                      combinational read data
//   msg_start_i                      request to send the ID message
//   msg_busy_o, msg_done_o           message pending / completion pulse
//   tx_data_o, tx_valid_o, tx_ready_i  byte handshake to the transmitter
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int          MSG_LEN    = 10,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] UART_BASE  = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    input  logic        msg_start_i,
    output logic        msg_busy_o,
    output logic        msg_done_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i
);

    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             last_grant;
    logic             msg_pend;
    logic             msg_done;
    logic             ovf;

    logic             wr_txd;
    logic             wr_clr;
    logic             q_push;
    logic             q_pop;
    logic             q_full;
    logic             q_empty;
    logic [7:0]       q_head;
    logic             tx_active;
    logic             last_byte;
    stat_t            stat;
    logic             unused_wdata;

    assign unused_wdata = ^cpu_wdata_i[31:8];

    assign wr_txd    = cpu_req_i && cpu_we_i && (cpu_addr_i == UART_BASE + TXD_OFF);
    assign wr_clr    = cpu_req_i && cpu_we_i && (cpu_addr_i == UART_BASE + CTRL_OFF)
                       && cpu_wdata_i[0];
    assign q_push    = wr_txd && !q_full;
    assign q_pop     = (state == ST_SEND_CPU) && tx_ready_i;
    assign tx_active = (state != ST_IDLE);
    assign last_byte = (idx == IDX_W'(MSG_LEN - 1));

    assign tx_valid_o = tx_active;
    assign msg_busy_o = msg_pend;
    assign msg_done_o = msg_done;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (q_pop),
        .wdata (cpu_wdata_i[7:0]),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    // Data is a pure function of registered state, so it cannot change while
    // the transmitter stalls: the FIFO head only moves on a pop, idx only on a transfer
    always_comb begin
        tx_data_o = 8'h00;
        if (state == ST_SEND_CPU) begin
            tx_data_o = q_head;
        end else if (state == ST_SEND_MSG) begin
            tx_data_o = id_rom_byte(32'(idx));
        end
    end

    always_comb begin
        stat.ovf       = ovf;
        stat.q_empty   = q_empty;
        stat.q_full    = q_full;
        stat.msg_busy  = msg_pend;
        stat.tx_active = tx_active;
        cpu_rdata_o    = 32'h0;
        if (cpu_addr_i == UART_BASE + STAT_OFF) begin
            cpu_rdata_o = {27'b0, stat};
        end
    end

    // An overflow in the same cycle as a clear leaves the flag set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (wr_txd && q_full) begin
            ovf <= 1'b1;
        end else if (wr_clr) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            last_grant <= GRANT_MSG;
            msg_pend   <= 1'b0;
            msg_done   <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            if (msg_start_i && !msg_pend) begin
                msg_pend <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    // Tie goes to whoever was not granted last
                    if (!q_empty && (!msg_pend || last_grant == GRANT_MSG)) begin
                        state      <= ST_SEND_CPU;
                        last_grant <= GRANT_CPU;
                    end else if (msg_pend) begin
                        state      <= ST_SEND_MSG;
                        last_grant <= GRANT_MSG;
                    end
                end
                ST_SEND_CPU: begin
                    if (tx_ready_i) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SEND_MSG: begin
                    if (tx_ready_i) begin
                        if (last_byte) begin
                            idx      <= '0;
                            msg_pend <= 1'b0;
                            msg_done <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
// Self-checking bench for uart_tx_sched: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a queue-based model of
// the scheduler, plus transfer-sequence checks against literal byte lists.
module tb_uart_tx_sched;

    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam logic [31:0] A_CTRL  = BASE;
    localparam logic [31:0] A_STAT  = BASE + 32'h4;
    localparam logic [31:0] A_TXD   = BASE + 32'h8;
    localparam int          MSG_LEN = 10;
    localparam int          DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic [31:0] cpu_rdata_o;
    logic        msg_start_i;
    logic        msg_busy_o;
    logic        msg_done_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .MSG_LEN    (MSG_LEN),
        .FIFO_DEPTH (DEPTH),
        .UART_BASE  (BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .msg_start_i (msg_start_i),
        .msg_busy_o  (msg_busy_o),
        .msg_done_o  (msg_done_o),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: byte queue, message progress and current grant
    string      id_str = "2023211013";
    logic [7:0] m_q[$];
    bit         m_ovf;
    bit         m_pend;
    int         m_idx;
    int         m_gr;        // 0 none, 1 CPU byte, 2 message
    bit         m_last_msg;
    bit         m_done;

    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int         done_seen;

    function automatic logic [7:0] rom_model(input int i);
        return 8'(id_str.getc(i));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf      = 0;
        m_pend     = 0;
        m_idx      = 0;
        m_gr       = 0;
        m_last_msg = 1;
        m_done     = 0;
    endtask

    // Advance the model across one rising edge using the inputs now applied
    task automatic model_step();
        int old_size;
        bit old_pend;
        int old_gr;
        bit wr_txd;
        bit wr_clr;
        bit cpu_w;
        old_size = m_q.size();
        old_pend = m_pend;
        old_gr   = m_gr;
        wr_txd   = cpu_req_i && cpu_we_i && (cpu_addr_i == A_TXD);
        wr_clr   = cpu_req_i && cpu_we_i && (cpu_addr_i == A_CTRL) && cpu_wdata_i[0];
        m_done   = 0;
        if (old_gr == 1 && tx_ready_i) begin
            void'(m_q.pop_front());
            m_gr = 0;
        end
        if (old_gr == 2 && tx_ready_i) begin
            m_idx++;
            if (m_idx == MSG_LEN) begin
                m_idx  = 0;
                m_pend = 0;
                m_done = 1;
                m_gr   = 0;
            end
        end
        if (wr_txd) begin
            if (old_size < DEPTH) m_q.push_back(cpu_wdata_i[7:0]);
            else m_ovf = 1;
        end else if (wr_clr) begin
            m_ovf = 0;
        end
        if (old_gr == 0) begin
            cpu_w = (old_size > 0) && (!old_pend || m_last_msg);
            if (cpu_w) begin
                m_gr       = 1;
                m_last_msg = 0;
            end else if (old_pend) begin
                m_gr       = 2;
                m_last_msg = 1;
            end
        end
        if (msg_start_i && !old_pend) m_pend = 1;
    endtask

    task automatic checkOutput();
        logic [7:0]  e_data;
        logic [31:0] e_rd;
        e_data = 8'h00;
        if (m_gr == 1) e_data = m_q[0];
        else if (m_gr == 2) e_data = rom_model(m_idx);
        e_rd = 32'h0;
        if (cpu_addr_i == A_STAT)
            e_rd = {27'b0, m_ovf, m_q.size() == 0, m_q.size() == DEPTH, m_pend, m_gr != 0};
        check("tx_valid", 32'(tx_valid_o), 32'(m_gr != 0));
        check("tx_data",  32'(tx_data_o),  32'(e_data));
        check("msg_busy", 32'(msg_busy_o), 32'(m_pend));
        check("msg_done", 32'(msg_done_o), 32'(m_done));
        check("rdata",    cpu_rdata_o,     e_rd);
        if (tx_valid_o && tx_ready_i) obs_q.push_back(tx_data_o);
        if (msg_done_o) done_seen++;
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic start, input logic ready);
        cpu_req_i   = req;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        msg_start_i = start;
        tx_ready_i  = ready;
        #1;
        checkOutput();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ready);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'h0, 32'h0, 0, ready);
    endtask

    // Reset pulse placed between clock edges
    task automatic do_reset();
        cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
        msg_start_i = 0; tx_ready_i = 0;
        rst = 0;
        #1;
        model_reset();
        checkOutput();
        #1;
        rst = 1;
    endtask

    task automatic checkSeq(input string tag);
        check({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check(tag, 32'(obs_q[i]), 32'(exp_q[i]));
    endtask

    task automatic exp_id();
        for (int i = 0; i < MSG_LEN; i++) exp_q.push_back(rom_model(i));
    endtask

    initial begin
        int sel;
        logic [31:0] addr;
        logic we;

        rst = 0; cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = A_STAT; cpu_wdata_i = 0;
        msg_start_i = 0; tx_ready_i = 0;
        model_reset();
        done_seen = 0;
        #2;
        checkOutput();
        check("reset_stat", cpu_rdata_o, 32'h0000_0008);
        @(posedge clk);
        #1;
        rst = 1;

        $display("[TB] two CPU bytes");
        obs_q.delete(); exp_q = '{8'h41, 8'h42};
        applyStimulus(1, 1, A_TXD, 32'h41, 0, 1);
        applyStimulus(1, 1, A_TXD, 32'h42, 0, 1);
        idle(6, 1);
        checkSeq("cpu_seq");

        $display("[TB] ID message");
        obs_q.delete(); exp_q.delete(); exp_id(); done_seen = 0;
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 1);
        idle(15, 1);
        checkSeq("msg_seq");
        check("msg_done_cnt", 32'(done_seen), 32'd1);
        check("msg_busy_end", 32'(msg_busy_o), 32'd0);

        $display("[TB] queue overflow");
        do_reset();
        obs_q.delete(); exp_q = '{8'h50, 8'h51, 8'h52, 8'h53};
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, A_TXD, 32'h50 + 32'(i), 0, 0);
        applyStimulus(1, 0, A_STAT, 32'h0, 0, 0);
        check("stat_ovf_full", cpu_rdata_o & 32'h1C, 32'h14);
        applyStimulus(1, 1, A_CTRL, 32'h1, 0, 0);
        applyStimulus(1, 0, A_STAT, 32'h0, 0, 0);
        check("stat_ovf_clr", cpu_rdata_o & 32'h1C, 32'h04);
        idle(12, 1);
        checkSeq("ovf_seq");

        $display("[TB] CPU and message tie");
        do_reset();
        obs_q.delete(); exp_q = '{8'hA0}; exp_id(); exp_q.push_back(8'hA1);
        applyStimulus(1, 1, A_TXD, 32'hA0, 1, 0);
        applyStimulus(1, 1, A_TXD, 32'hA1, 0, 0);
        idle(30, 1);
        checkSeq("tie_seq");

        $display("[TB] stalled message");
        obs_q.delete(); exp_q.delete(); exp_id();
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 1);
        idle(4, 1);
        check("stall_data", 32'(tx_data_o), 32'h33);
        idle(7, 0);
        check("stall_hold", 32'(tx_data_o), 32'h33);
        idle(15, 1);
        checkSeq("stall_seq");

        $display("[TB] reset during message");
        do_reset();
        obs_q.delete(); done_seen = 0;
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 1);
        idle(5, 1);
        check("rst_mid_byte", 32'(tx_data_o), 32'h32);
        do_reset();
        check("rst_valid", 32'(tx_valid_o), 32'd0);
        check("rst_busy",  32'(msg_busy_o), 32'd0);
        idle(15, 1);
        check("rst_no_done", 32'(done_seen), 32'd0);
        check("rst_xfers",   32'(obs_q.size()), 32'd4);

        $display("[TB] random traffic");
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            sel = int'($urandom_range(0, 9));
            if (sel <= 4) addr = A_TXD;
            else if (sel == 5) addr = A_CTRL;
            else if (sel <= 7) addr = A_STAT;
            else addr = BASE + 32'hC;
            we = (sel <= 5) ? 1'b1 : ($urandom_range(0, 3) == 0);
            applyStimulus(sel != 9, we, addr, $urandom,
                          $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter MSG_LEN, default 10, number of bytes in the built-in ID message.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, CPU byte queue depth (power of two).
REQ-003 SHALL have parameter UART_BASE, default 32'h3000_0000, base address of the UART register window.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cpu_req_i  input  1  CPU bus access strobe.
REQ-007 SHALL have port cpu_we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cpu_addr_i  input  32  bus address.
REQ-009 SHALL have port cpu_wdata_i  input  32  write data; only bits [7:0] are used.
REQ-010 SHALL have port cpu_rdata_o  output  32  read data, combinational.
REQ-011 SHALL have port msg_start_i  input  1  one-cycle request to transmit the ID message.
REQ-012 SHALL have port msg_busy_o  output  1  message pending or in transmission.
REQ-013 SHALL have port msg_done_o  output  1  one-cycle pulse after the last message byte transfers.
REQ-014 SHALL have port tx_data_o  output  8  byte to the UART transmitter.
REQ-015 SHALL have port tx_valid_o  output  1  tx_data_o is valid.
REQ-016 SHALL have port tx_ready_i  input  1  transmitter idle; a transfer occurs when tx_valid_o && tx_ready_i.

Function
REQ-017 Write (cpu_req_i && cpu_we_i) to UART_BASE+8 with queue not full SHALL push cpu_wdata_i[7:0]; when full, the byte SHALL be dropped and sticky ovf set.
REQ-018 Write to UART_BASE+0 with wdata[0]=1 SHALL clear ovf; a simultaneous overflow event SHALL win.
REQ-019 Read of UART_BASE+4 SHALL return {27'b0, ovf, q_empty, q_full, msg_busy_o, tx_active}; other addresses SHALL return 0.
REQ-020 Message ROM SHALL hold ASCII "2023211013" (32h,30h,32h,33h,32h,31h,31h,30h,31h,33h), bytes 0..MSG_LEN-1 sent in index order.
REQ-021 msg_start_i SHALL set msg_pend only when msg_busy_o=0; while busy it SHALL be ignored.
REQ-022 FSM states: IDLE, SEND_CPU, SEND_MSG; tx_active = state != IDLE; tx_valid_o = tx_active (registered state, no combinational path from requests).
REQ-023 In IDLE with only the queue non-empty, next state SHALL be SEND_CPU; with only msg_pend set, SEND_MSG; with neither, IDLE.
REQ-024 In IDLE with both pending, grant SHALL go to the requester not recorded in last_grant (round robin); last_grant SHALL be updated on every grant.
REQ-025 SEND_CPU SHALL present the queue head; on transfer, pop one entry and return to IDLE (one byte per grant).
REQ-026 SEND_MSG SHALL present rom[idx]; on transfer idx increments; the message is not preemptible until complete.
REQ-027 On transfer with idx = MSG_LEN-1: idx->0, msg_pend->0, msg_done_o=1 for the next cycle, state->IDLE.
REQ-028 tx_data_o SHALL remain stable while tx_valid_o=1 and tx_ready_i=0.
REQ-029 Latency: request visible in IDLE at cycle N -> tx_valid_o=1 at cycle N+1; minimum of one IDLE cycle between grants.
REQ-030 Simultaneous push and pop SHALL both take effect; push into a full queue SHALL be dropped even when a pop occurs in the same cycle.

Reset
REQ-031 On rst=0, asynchronously: state IDLE, queue empty, ovf=0, msg_pend=0, idx=0, last_grant=MSG (CPU wins first tie), msg_done_o=0, tx_valid_o=0, tx_data_o=0.
REQ-032 Reset mid-transfer SHALL abandon the byte and the message; no msg_done_o SHALL be generated.

Structure
REQ-033 A shared package SHALL hold the UART register offsets (CTRL 0, STAT 4, TXD 8), the FSM state encoding, and the ID ROM constant.
REQ-034 The CPU queue SHALL be sub-module uart_tx_fifo (synchronous FIFO with full/empty flags, same clk/rst).

Verification
REQ-035 Write 41h, 42h to +8 with tx_ready_i=1 -> tx_data_o 41h then 42h, with tx_valid_o low for one cycle between them.
REQ-036 msg_start_i pulse, tx_ready_i=1 -> 10 transfers 32h..33h in order, then msg_done_o pulse, then msg_busy_o=0.
REQ-037 Queue 5 bytes with tx_ready_i=0 -> fifth byte dropped, status read = 14h (ovf|q_full); write 1 to +0 -> ovf cleared.
REQ-038 Queue non-empty and msg pending in IDLE after reset -> CPU byte sent first, then all 10 message bytes uninterrupted, then the remaining CPU bytes.
REQ-039 tx_ready_i held low 7 cycles during SEND_MSG -> tx_data_o stable, idx unchanged.
REQ-040 Assert rst at message byte 4 -> all outputs 0, msg_busy_o=0, no msg_done_o pulse.
